// File: rtl/shift_normalizer_if.sv
// Start/done handshake and result bus between the controller and shift_normalizer.
interface shift_normalizer_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic             right;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    count;
  logic             zero;

  modport master (
    output start, in, right,
    input  ready, busy, done, out, count, zero
  );

  modport slave (
    input  start, in, right,
    output ready, busy, done, out, count, zero
  );
endinterface

// File: rtl/shift_normalizer.sv
// Sequential normalizer: shifts an operand toward its target end bit and reports the shift count.
// Optional SHIFT_NORM_DUAL_EN enables two-position steps when the target bit and its neighbour are both clear.
module shift_normalizer #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_normalizer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r, r_nxt;
  logic [CW-1:0]    c, c_nxt;
  logic             d, d_nxt;
  logic             z, z_nxt;
  logic             target;

  // D=0 normalizes toward the MSB, D=1 toward the LSB.
  assign target = d ? r[0] : r[WIDTH-1];

`ifdef SHIFT_NORM_DUAL_EN
  logic neighbour;
  assign neighbour = d ? r[1] : r[WIDTH-2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
      d     <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      c     <= c_nxt;
      d     <= d_nxt;
      z     <= z_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    c_nxt     = c;
    d_nxt     = d;
    z_nxt     = z;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          r_nxt     = bus.in;
          d_nxt     = bus.right;
          c_nxt     = '0;
          z_nxt     = (bus.in == '0);
          state_nxt = (bus.in == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (target) begin
          state_nxt = DONE;
        end
`ifdef SHIFT_NORM_DUAL_EN
        else if (!neighbour) begin
          r_nxt = d ? (r >> 2) : (r << 2);
          c_nxt = c + CW'(2);
        end
`endif
        else begin
          r_nxt = d ? (r >> 1) : (r << 1);
          c_nxt = c + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Results are read straight from the datapath; they hold from DONE until the next accept.
  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.out   = r;
  assign bus.count = c;
  assign bus.zero  = z;

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: latency-level reference model plus directed vectors.
// Latency expectations follow SHIFT_NORM_DUAL_EN when it is defined.
module tb_shift_normalizer;

  localparam int WIDTH = 8;
  localparam int CW    = 3;

`ifdef SHIFT_NORM_DUAL_EN
  localparam int LAT0 = 1;
  localparam int LAT3 = 3;
  localparam int LAT6 = 4;
  localparam int LAT7 = 5;
`else
  localparam int LAT0 = 1;
  localparam int LAT3 = 4;
  localparam int LAT6 = 7;
  localparam int LAT7 = 8;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   checking = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   edge_count = 0;

  shift_normalizer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  shift_normalizer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_count++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: result from the position of the extreme set bit, timing from a latency count.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;
  mstate_t    m_state = M_IDLE;
  int         m_left  = 0;
  int         m_n     = 0;
  logic [7:0] m_out   = 8'h00;
  int         m_count = 0;
  logic       m_zero  = 1'b0;

  function automatic void normalize(input logic [7:0] v, input logic rt, output logic [7:0] o, output int n);
    n = 0;
    o = v;
    if (v != 8'h00) begin
      if (!rt) begin
        for (int i = 0; i < 8; i++) if (v[i]) n = 7 - i;
        o = v << n;
      end else begin
        for (int i = 7; i >= 0; i--) if (v[i]) n = i;
        o = v >> n;
      end
    end
  endfunction

  function automatic int latency(input int n);
`ifdef SHIFT_NORM_DUAL_EN
    return (n + 1) / 2 + 1;
`else
    return n + 1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE;
      m_out   = 8'h00;
      m_count = 0;
      m_zero  = 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (bus.start) begin
            normalize(bus.in, bus.right, m_out, m_n);
            m_count = m_n;
            m_zero  = (bus.in == 8'h00);
            if (m_zero) begin
              m_state = M_DONE;
            end else begin
              m_left  = latency(m_n);
              m_state = M_BUSY;
            end
          end
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) m_state = M_DONE;
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("ready", {31'b0, bus.ready}, {31'b0, m_state == M_IDLE});
      checkOutput("busy",  {31'b0, bus.busy},  {31'b0, m_state != M_IDLE});
      checkOutput("done",  {31'b0, bus.done},  {31'b0, m_state == M_DONE});
      checkOutput("zero",  {31'b0, bus.zero},  {31'b0, m_zero});
      if (m_state != M_BUSY) begin
        checkOutput("out",   {24'b0, bus.out}, {24'b0, m_out});
        checkOutput("count", {29'b0, bus.count}, m_count);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] v, input logic rt, input bit hammer, input int exp_lat,
                               input logic [7:0] exp_out, input int exp_count, input logic exp_zero);
    int k;
    int e;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = v;
    bus.right = rt;
    @(posedge clk);
    #1;
    k = edge_count;
    if (hammer) begin
      bus.in = 8'hFF;
    end else begin
      bus.start = 1'b0;
      bus.in    = 8'hA5;
      bus.right = ~rt;
    end
    pulses = 0;
    e = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (e < 0) e = edge_count;
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    checkOutput("done_pulses", pulses, 1);
    checkOutput("latency", e - k, exp_lat);
    checkOutput("lit_out",   {24'b0, bus.out}, {24'b0, exp_out});
    checkOutput("lit_count", {29'b0, bus.count}, exp_count);
    checkOutput("lit_zero",  {31'b0, bus.zero}, {31'b0, exp_zero});
    checkOutput("model_out",   {24'b0, m_out}, {24'b0, exp_out});
    checkOutput("model_count", m_count, exp_count);
  endtask

  initial begin
    int pulses;
    bus.start = 1'b0;
    bus.in    = 8'h00;
    bus.right = 1'b0;
    #1 rst_n = 1'b0;
    checking = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'b0, bus.ready}, 32'd1);
    checkOutput("rst_out",   {24'b0, bus.out}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(8'h80, 1'b0, 1'b0, LAT0, 8'h80, 0, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0, LAT7, 8'h80, 7, 1'b0);
    applyStimulus(8'h28, 1'b1, 1'b0, LAT3, 8'h05, 3, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 0,    8'h00, 0, 1'b1);
    applyStimulus(8'h03, 1'b0, 1'b1, LAT6, 8'hC0, 6, 1'b0);
    applyStimulus(8'h80, 1'b1, 1'b0, LAT7, 8'h01, 7, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0, LAT0, 8'hFF, 0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 0,    8'h00, 0, 1'b1);

    // Abandon an operation mid-shift with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = 8'h01;
    bus.right = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_ready", {31'b0, bus.ready}, 32'd1);
    checkOutput("arst_busy",  {31'b0, bus.busy}, 32'd0);
    checkOutput("arst_out",   {24'b0, bus.out}, 32'd0);
    checkOutput("arst_count", {29'b0, bus.count}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checkOutput("arst_no_done", pulses, 0);
    rst_n = 1'b1;
    applyStimulus(8'h10, 1'b0, 1'b0, LAT3, 8'h80, 3, 1'b0);

    @(negedge clk);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Sequential normalizer for the datapath shift unit: given an 8-bit operand and a direction, it shifts one position per clock until the target end bit is set, then reports the normalized value and the number of positions shifted. It performs the inverse of the shift-by-count operation by deriving the count from the data (leading-zero count for left, trailing-zero count for right). It sits beside the combinational shifter and is driven by the controller through a start/done handshake.

## Interface

- WIDTH, 8, operand width; must be a power of two ≥ 4.
- CW, 3, count width; must equal log2(WIDTH).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- in  input  WIDTH  operand, captured on the accepting edge.
- right  input  1  direction, captured with in. 0 = normalize toward bit WIDTH-1 (left); 1 = normalize toward bit 0 (right).
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse: results valid.
- out  output  WIDTH  normalized value.
- count  output  CW  positions shifted.
- zero  output  1  operand was all zeros.

## Operation

- Datapath: work register R (WIDTH), direction flag D, counter C (CW).
- IDLE: ready=1. On an edge with start=1, capture R<=in, D<=right, C<=0, and clear zero. If in==0, set zero<=1 and go to DONE; otherwise go to SHIFT.
- SHIFT: the target bit is R[WIDTH-1] when D=0 and R[0] when D=1.
  - Target set: go to DONE.
  - Target clear, D=0: R<={R[WIDTH-2:0],1'b0} and C<=C+1.
  - Target clear, D=1: R<={1'b0,R[WIDTH-1:1]} and C<=C+1.
  - No rotation; vacated bits are zero.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE unconditionally.
- out, count and zero are driven from R, C and the zero flag. They stay stable from DONE until the next accepted start.
- C never wraps: a nonzero operand needs at most WIDTH-1 shifts.
- Zero operand: out=0, count=0, zero=1, and no shifting takes place.
- start while busy is ignored; no queuing.
- start during DONE is ignored because ready=0.
- in and right are don't-care except on the accepting edge.

## Timing

- Reset (async assert, whatever the state): state=IDLE. Outputs go to ready=1, busy=0, done=0, out=0, count=0, zero=0. Reset mid-SHIFT abandons the operation and produces no done pulse.
- Deassertion of rst_n is synchronized by the integrator. The first accept can happen on the first edge after release.
- Accept at edge k with a nonzero operand needing N shifts (0 ≤ N ≤ WIDTH-1):
  - SHIFT occupies edges k+1 … k+N+1.
  - done is high in the cycle after edge k+N+1.
  - IDLE is re-entered at edge k+N+2.
- Accept at edge k with in==0: done is high in the cycle after edge k, and IDLE is re-entered at edge k+1.
- Minimum start-to-start spacing is N+3 edges, or 2 edges for a zero operand.

## Configuration

- Macro: SHIFT_NORM_DUAL_EN.
- Defined: SHIFT takes a double step when both the target bit and its neighbour are clear (D=0: R[WIDTH-1] and R[WIDTH-2]; D=1: R[0] and R[1]). A double step shifts by 2 and sets C<=C+2.
  - If only the target bit is clear, it takes a single step as above.
  - out, count and zero are identical to the undefined build.
  - SHIFT length becomes ⌊N/2⌋ + (N mod 2) step cycles plus one detect cycle.
- Undefined: single step only, with the latency given above.

## Test plan

- Reset, then start with in=0x80, right=0 at edge k → done in the cycle after edge k+1; out=0x80, count=0, zero=0.
- in=0x01, right=0 at edge k → done after edge k+8; out=0x80, count=7. With SHIFT_NORM_DUAL_EN: done after edge k+5, with the same out and count.
- in=0x28, right=1 → out=0x05, count=3, zero=0. Then in=0x00, right=1 → done after the accepting edge; out=0x00, count=0, zero=1.
- in=0x03, right=0 accepted; pulse start=1 with in=0xFF on every following edge while busy → exactly one done; out=0xC0, count=6. The next accept happens only once ready=1.
- in=0x01, right=0 accepted; assert rst_n=0 asynchronously three cycles later → immediately state IDLE with out=0, count=0, ready=1, and no done pulse. After release, in=0x10, right=0 → out=0x80, count=3.
